// File: rtl/adrv9001_rx_pkt_if.sv
// ---------------------------------------------------------------------------
// adrv9001_rx_pkt_if
// AXI-Stream style bundle used on both sides of the rx packetiser.
//   tdata  : sample (I in [31:16], Q in [15:0] for 32-bit samples)
//   tvalid : beat valid
//   tready : sink ready (the rx source side ignores it, it never stalls)
//   tlast  : last beat of a packet
//   tuser  : 32-bit sample timestamp, only present when
//            ADRV9001_RX_PKT_TIMESTAMP_EN is defined
// Modports: master drives data/valid/last(/user) and receives tready;
//           slave is the mirror image.
// ---------------------------------------------------------------------------
interface adrv9001_rx_pkt_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
`ifdef ADRV9001_RX_PKT_TIMESTAMP_EN
    logic [31:0]           tuser;
`endif

    modport master (
`ifdef ADRV9001_RX_PKT_TIMESTAMP_EN
        output tuser,
`endif
        output tdata, tvalid, tlast,
        input  tready
    );

    modport slave (
`ifdef ADRV9001_RX_PKT_TIMESTAMP_EN
        input  tuser,
`endif
        input  tdata, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/adrv9001_rx_pkt.sv
// ---------------------------------------------------------------------------
// adrv9001_rx_pkt
// Frames the non-stalling ADRV9001 rx sample stream into fixed-length
// packets (tlast every len_q accepted beats) and buffers them in a small
// first-word-fall-through FIFO toward a backpressuring consumer. Beats that
// find the FIFO full are dropped, counted and flagged instead of stalling.
//
// Ports:
//   axis_aclk     : sample clock
//   axis_rstn     : asynchronous active-low reset
//   enable        : capture arm; a started packet is always completed
//   pkt_len       : samples per packet (0 treated as 1), latched per packet
//   s_axis        : rx sample input (slave; tready tied high)
//   m_axis        : framed output (master) with tlast (and tuser)
//   busy          : high while capturing or draining
//   overflow      : sticky drop flag
//   overflow_clr  : clears overflow and drop_cnt
//   drop_cnt      : saturating dropped-beat count
//
// Optional feature macro: ADRV9001_RX_PKT_TIMESTAMP_EN
//   Adds a free-running sample counter whose pre-increment value is stored
//   with each accepted beat and presented on m_axis.tuser.
// ---------------------------------------------------------------------------
module adrv9001_rx_pkt #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  axis_aclk,
    input  logic                  axis_rstn,
    input  logic                  enable,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    adrv9001_rx_pkt_if.slave      s_axis,
    adrv9001_rx_pkt_if.master     m_axis,
    output logic                  busy,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic [31:0]           drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
`ifdef ADRV9001_RX_PKT_TIMESTAMP_EN
    localparam int EW = DATA_WIDTH + 1 + 32;
`else
    localparam int EW = DATA_WIDTH + 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    function automatic logic [LEN_WIDTH-1:0] norm_len(input logic [LEN_WIDTH-1:0] l);
        return (l == '0) ? LEN_WIDTH'(1) : l;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t                 state_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   beat_q;
    logic [PW-1:0]          wr_ptr_q;
    logic [PW-1:0]          rd_ptr_q;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic                   overflow_q;
    logic [31:0]            drop_cnt_q;

    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   rd_fire;
    logic                   wr_req;
    logic                   wr_ok;
    logic                   drop;
    logic                   tlast_in;
    logic [EW-1:0]          wr_entry;
    logic [EW-1:0]          rd_entry;

    // The source has no backpressure path; it is always "ready".
    assign s_axis.tready = 1'b1;

    // Full: same slot index, different lap bit.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_fire  = !fifo_empty && m_axis.tready;
    assign wr_req   = (state_q == ST_CAPTURE) && s_axis.tvalid;
    // A full FIFO still takes a beat when a slot frees in the same cycle.
    assign wr_ok    = wr_req && (!fifo_full || rd_fire);
    assign drop     = wr_req && !wr_ok;
    assign tlast_in = (beat_q == len_q - LEN_WIDTH'(1));

`ifdef ADRV9001_RX_PKT_TIMESTAMP_EN
    logic [31:0] ts_q;

    // Counts every offered sample, dropped or not, so tuser gaps reveal drops.
    always_ff @(posedge axis_aclk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            ts_q <= '0;
        end else if (s_axis.tvalid) begin
            ts_q <= ts_q + 32'd1;
        end
    end

    assign wr_entry    = {ts_q, tlast_in, s_axis.tdata};
    assign m_axis.tuser = fifo_empty ? 32'd0 : rd_entry[EW-1 -: 32];
`else
    assign wr_entry = {tlast_in, s_axis.tdata};
`endif

    // Packet framing FSM
    always_ff @(posedge axis_aclk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            state_q <= ST_IDLE;
            len_q   <= LEN_WIDTH'(1);
            beat_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        len_q   <= norm_len(pkt_len);
                        beat_q  <= '0;
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // Dropped beats do not count, so delivered packets stay whole.
                    if (wr_ok) begin
                        if (tlast_in) begin
                            beat_q <= '0;
                            if (enable) begin
                                len_q <= norm_len(pkt_len);
                            end else begin
                                state_q <= ST_DRAIN;
                            end
                        end else begin
                            beat_q <= beat_q + LEN_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // FIFO pointers
    always_ff @(posedge axis_aclk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // FIFO storage (data path, not reset)
    always_ff @(posedge axis_aclk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    // Overflow flag and drop counter; a clear wins over a same-cycle drop
    // for the flag, but that drop is still counted.
    always_ff @(posedge axis_aclk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (overflow_clr) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= drop ? 32'd1 : 32'd0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            drop_cnt_q <= sat_inc32(drop_cnt_q);
        end
    end

    // First-word-fall-through output; zeroed while empty so reset shows 0.
    assign rd_entry      = mem_q[rd_ptr_q[AW-1:0]];
    assign m_axis.tvalid = !fifo_empty;
    assign m_axis.tdata  = fifo_empty ? '0 : rd_entry[DATA_WIDTH-1:0];
    assign m_axis.tlast  = !fifo_empty && rd_entry[DATA_WIDTH];

    assign busy     = (state_q != ST_IDLE);
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule
